// File: rtl/acondicionador_sensores.sv
// acondicionador_sensores
// Input-conditioning stage that sits in front of the PCorto1Final controller.
// The motor and presence switches go through a 2-flop synchroniser and a
// debouncer. The temperature word is sampled periodically and glitch-filtered.
//
// Parameters
//   DEB_CYCLES  consecutive synchronised cycles a switch must differ from its
//               output before the output flips (>= 2)
//   SAMPLE_DIV  temperature sample period in CLK cycles (>= 2)
//
// Ports
//   CLK           in   1  system clock, rising edge
//   Reset         in   1  asynchronous active-low reset
//   TempRaw       in   5  unsigned temperature code, quasi-static
//   MotorRaw      in   1  raw motor switch (asynchronous, bouncy)
//   PresenciaRaw  in   1  raw presence sensor (asynchronous, bouncy)
//   Temperatura   out  5  filtered temperature, registered
//   Motor         out  1  debounced motor switch, registered
//   Presencia     out  1  debounced presence, registered
//   TempValid     out  1  one-cycle pulse when a new Temperatura is accepted
//
// Build option
//   TEMP_AVG_EN   when defined, the two-equal-samples filter is replaced by a
//                 4-sample moving average with a FILL/RUN start-up phase.

module acondicionador_sensores #(
  parameter int DEB_CYCLES = 4,
  parameter int SAMPLE_DIV = 8
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [4:0] TempRaw,
  input  logic       MotorRaw,
  input  logic       PresenciaRaw,
  output logic [4:0] Temperatura,
  output logic       Motor,
  output logic       Presencia,
  output logic       TempValid
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int SW = $clog2(SAMPLE_DIV);
  localparam logic [DW-1:0] DEB_TERM = DW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0] DIV_TERM = SW'(SAMPLE_DIV - 1);

  logic [1:0]    r_motorSync;
  logic [1:0]    r_presSync;
  logic [DW-1:0] r_motorCnt;
  logic [DW-1:0] r_presCnt;
  logic [SW-1:0] r_div;
  logic [4:0]    r_trQ;
  logic          w_strobe;

  // Two-flop synchronisers for both switch inputs; bit 1 is the safe copy.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_motorSync <= 2'b00;
      r_presSync  <= 2'b00;
    end else begin
      r_motorSync <= {r_motorSync[0], MotorRaw};
      r_presSync  <= {r_presSync[0], PresenciaRaw};
    end
  end

  // Motor debounce: count consecutive cycles where the synchronised value
  // disagrees with the output, flip once the run reaches DEB_CYCLES.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_motorCnt <= '0;
      Motor      <= 1'b0;
    end else if (r_motorSync[1] == Motor) begin
      r_motorCnt <= '0;
    end else if (r_motorCnt == DEB_TERM) begin
      Motor      <= ~Motor;
      r_motorCnt <= '0;
    end else begin
      r_motorCnt <= r_motorCnt + 1'b1;
    end
  end

  // Presence debounce, same rule as the motor path.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_presCnt <= '0;
      Presencia <= 1'b0;
    end else if (r_presSync[1] == Presencia) begin
      r_presCnt <= '0;
    end else if (r_presCnt == DEB_TERM) begin
      Presencia <= ~Presencia;
      r_presCnt <= '0;
    end else begin
      r_presCnt <= r_presCnt + 1'b1;
    end
  end

  // Sample divider and raw temperature capture. The word is only consumed at
  // the strobe, so a single register stage is enough here.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_div <= '0;
      r_trQ <= 5'd0;
    end else begin
      r_trQ <= TempRaw;
      if (r_div == DIV_TERM) r_div <= '0;
      else                   r_div <= r_div + 1'b1;
    end
  end

  assign w_strobe = (r_div == DIV_TERM);

`ifdef TEMP_AVG_EN

  typedef enum logic {FILL, RUN} tempState_t;

  tempState_t r_state;
  tempState_t w_nextState;
  logic       w_update;
  logic [1:0] r_fillCnt;
  // Three older samples; at a strobe the newest history entry is r_trQ itself.
  logic [4:0] r_hist [3];
  logic [6:0] w_sum;

  assign w_sum = {2'b00, r_trQ} + {2'b00, r_hist[0]} + {2'b00, r_hist[1]}
               + {2'b00, r_hist[2]};

  // State register for the averaging filter start-up.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) r_state <= FILL;
    else        r_state <= w_nextState;
  end

  // Stay in FILL until the fourth strobe since reset has filled the history.
  always_comb begin
    w_nextState = r_state;
    w_update    = 1'b0;
    case (r_state)
      FILL: begin
        if (w_strobe && (r_fillCnt == 2'd3)) begin
          w_nextState = RUN;
          w_update    = 1'b1;
        end
      end
      RUN: begin
        w_update = w_strobe;
      end
      default: w_nextState = FILL;
    endcase
  end

  // History shift, fill counter and averaged output.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_fillCnt   <= 2'd0;
      r_hist[0]   <= 5'd0;
      r_hist[1]   <= 5'd0;
      r_hist[2]   <= 5'd0;
      Temperatura <= 5'd0;
      TempValid   <= 1'b0;
    end else begin
      TempValid <= w_update;
      if (w_strobe) begin
        r_hist[0] <= r_trQ;
        r_hist[1] <= r_hist[0];
        r_hist[2] <= r_hist[1];
        if (r_state == FILL) r_fillCnt <= r_fillCnt + 1'b1;
      end
      if (w_update) Temperatura <= w_sum[6:2];
    end
  end

`else

  logic [4:0] r_samp;

  // Two-equal-samples filter: a value is accepted only when the current
  // strobe sees the same word as the previous one.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_samp      <= 5'd0;
      Temperatura <= 5'd0;
      TempValid   <= 1'b0;
    end else begin
      TempValid <= 1'b0;
      if (w_strobe) begin
        r_samp <= r_trQ;
        if (r_trQ == r_samp) begin
          Temperatura <= r_trQ;
          TempValid   <= 1'b1;
        end
      end
    end
  end

`endif

endmodule

// File: tb/tb_acondicionador_sensores.sv
`timescale 1ns/1ps

module tb_acondicionador_sensores;

   localparam int DEB = 4;
   localparam int DIV = 8;

   logic       CLK = 1'b0;
   logic       Reset = 1'b1;
   logic [4:0] TempRaw = 5'd0;
   logic       MotorRaw = 1'b0;
   logic       PresenciaRaw = 1'b0;
   logic [4:0] Temperatura;
   logic       Motor;
   logic       Presencia;
   logic       TempValid;

   int checks = 0;
   int passes = 0;

   logic [4:0] rT;
   logic       rM;
   logic       rP;
   int         rLen;

   acondicionador_sensores #(
      .DEB_CYCLES(DEB),
      .SAMPLE_DIV(DIV)
   ) dut (
      .CLK(CLK),
      .Reset(Reset),
      .TempRaw(TempRaw),
      .MotorRaw(MotorRaw),
      .PresenciaRaw(PresenciaRaw),
      .Temperatura(Temperatura),
      .Motor(Motor),
      .Presencia(Presencia),
      .TempValid(TempValid)
   );

   // Free-running 100 MHz clock.
   always #5 CLK = ~CLK;

   // Reference model state. Temperature side works from edge counts since
   // reset and the list of strobe samples; switch side keeps a window of the
   // last DEB synchronised values and flips when all of them disagree.
   int         mEdges;
   int         mSum;
   logic [4:0] mPrevRaw;
   logic [4:0] mLastSamp;
   logic [4:0] mTemp;
   logic       mValid;
   logic [4:0] mHist[$];
   logic [1:0] mMotPipe;
   logic [1:0] mPresPipe;
   logic [DEB-1:0] mMotWin;
   logic [DEB-1:0] mPresWin;
   logic       mMotor;
   logic       mPres;

   // Behavioural model advanced on every active edge, cleared by reset.
   always @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         mEdges    = 0;
         mPrevRaw  = 5'd0;
         mLastSamp = 5'd0;
         mTemp     = 5'd0;
         mValid    = 1'b0;
         mHist     = {};
         mMotPipe  = 2'b00;
         mPresPipe = 2'b00;
         mMotWin   = '0;
         mPresWin  = '0;
         mMotor    = 1'b0;
         mPres     = 1'b0;
      end else begin
         mEdges++;
         mValid = 1'b0;
         if (mEdges % DIV == 0) begin
`ifdef TEMP_AVG_EN
            mHist.push_back(mPrevRaw);
            if (mHist.size() > 4) void'(mHist.pop_front());
            if (mHist.size() == 4) begin
               mSum   = int'(mHist[0]) + int'(mHist[1]) + int'(mHist[2]) + int'(mHist[3]);
               mTemp  = 5'(mSum / 4);
               mValid = 1'b1;
            end
`else
            if (mPrevRaw == mLastSamp) begin
               mTemp  = mPrevRaw;
               mValid = 1'b1;
            end
            mLastSamp = mPrevRaw;
`endif
         end
         mPrevRaw = TempRaw;

         mMotWin  = {mMotWin[DEB-2:0], mMotPipe[1]};
         mMotPipe = {mMotPipe[0], MotorRaw};
         if (mMotWin == {DEB{~mMotor}}) mMotor = ~mMotor;

         mPresWin  = {mPresWin[DEB-2:0], mPresPipe[1]};
         mPresPipe = {mPresPipe[0], PresenciaRaw};
         if (mPresWin == {DEB{~mPres}}) mPres = ~mPres;
      end
   end

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Compare every output against the reference model.
   task automatic checkOutput(input string tag);
      checkVal({tag, ".Temperatura"}, 32'(Temperatura), 32'(mTemp));
      checkVal({tag, ".TempValid"}, 32'(TempValid), 32'(mValid));
      checkVal({tag, ".Motor"}, 32'(Motor), 32'(mMotor));
      checkVal({tag, ".Presencia"}, 32'(Presencia), 32'(mPres));
   endtask

   // Drive inputs away from the edge, step n cycles, check after each one.
   task automatic applyStimulus(input logic [4:0] t, input logic m, input logic p,
                                input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         TempRaw      = t;
         MotorRaw     = m;
         PresenciaRaw = p;
         @(posedge CLK);
         @(negedge CLK);
         checkOutput(tag);
      end
   endtask

   // Directed scenarios followed by a randomized soak.
   initial begin
      #1 Reset = 1'b0;
      for (int i = 0; i < 20; i++)
         applyStimulus(5'($urandom), 1'($urandom), 1'($urandom), 1, "rst_hold");
      checkVal("rst_temp", 32'(Temperatura), 0);
      checkVal("rst_valid", 32'(TempValid), 0);
      checkVal("rst_motor", 32'(Motor), 0);
      checkVal("rst_pres", 32'(Presencia), 0);
      Reset = 1'b1;

`ifdef TEMP_AVG_EN
      applyStimulus(5'd4, 1'b0, 1'b0, 8, "s6_a");
      checkVal("s6_fill1", 32'(TempValid), 0);
      applyStimulus(5'd8, 1'b0, 1'b0, 8, "s6_b");
      checkVal("s6_fill2", 32'(TempValid), 0);
      applyStimulus(5'd12, 1'b0, 1'b0, 8, "s6_c");
      checkVal("s6_fill3", 32'(TempValid), 0);
      applyStimulus(5'd16, 1'b0, 1'b0, 8, "s6_d");
      checkVal("s6_valid4", 32'(TempValid), 1);
      checkVal("s6_avg10", 32'(Temperatura), 10);
      applyStimulus(5'd20, 1'b0, 1'b0, 8, "s6_e");
      checkVal("s6_valid5", 32'(TempValid), 1);
      checkVal("s6_avg14", 32'(Temperatura), 14);
`else
      applyStimulus(5'd0, 1'b0, 1'b0, 7, "s1_wait");
      checkVal("s1_novalid", 32'(TempValid), 0);
      applyStimulus(5'd0, 1'b0, 1'b0, 1, "s1_strobe");
      checkVal("s1_valid", 32'(TempValid), 1);
      checkVal("s1_temp", 32'(Temperatura), 0);

      Reset = 1'b0;
      applyStimulus(5'd3, 1'b0, 1'b0, 2, "s2_rst");
      Reset = 1'b1;
      applyStimulus(5'd3, 1'b0, 1'b0, 8, "s2_a");
      checkVal("s2_reject", 32'(TempValid), 0);
      checkVal("s2_temp0", 32'(Temperatura), 0);
      applyStimulus(5'd3, 1'b0, 1'b0, 8, "s2_b");
      checkVal("s2_valid", 32'(TempValid), 1);
      checkVal("s2_temp3", 32'(Temperatura), 3);
      applyStimulus(5'd3, 1'b0, 1'b0, 7, "s2_c");
      checkVal("s2_gap", 32'(TempValid), 0);
      applyStimulus(5'd3, 1'b0, 1'b0, 1, "s2_d");
      checkVal("s2_repeat", 32'(TempValid), 1);

      applyStimulus(5'd3, 1'b0, 1'b0, 3, "s3_a");
      applyStimulus(5'd31, 1'b0, 1'b0, 4, "s3_glitch");
      applyStimulus(5'd3, 1'b0, 1'b0, 9, "s3_b");
      checkVal("s3_glitch_temp", 32'(Temperatura), 3);
      checkVal("s3_glitch_valid", 32'(TempValid), 0);
      applyStimulus(5'd3, 1'b0, 1'b0, 8, "s3_c");
      checkVal("s3_back_temp", 32'(Temperatura), 3);
      checkVal("s3_back_valid", 32'(TempValid), 1);
      applyStimulus(5'd31, 1'b0, 1'b0, 8, "s3_d");
      checkVal("s3_first31", 32'(Temperatura), 3);
      applyStimulus(5'd31, 1'b0, 1'b0, 8, "s3_e");
      checkVal("s3_second31", 32'(Temperatura), 31);
      checkVal("s3_valid31", 32'(TempValid), 1);

      applyStimulus(5'd31, 1'b0, 1'b1, 3, "s4_short");
      applyStimulus(5'd31, 1'b0, 1'b0, 10, "s4_quiet");
      checkVal("s4_short_pres", 32'(Presencia), 0);
      applyStimulus(5'd31, 1'b0, 1'b1, 5, "s4_rise");
      checkVal("s4_edge5", 32'(Presencia), 0);
      applyStimulus(5'd31, 1'b0, 1'b1, 1, "s4_rise6");
      checkVal("s4_edge6", 32'(Presencia), 1);
      applyStimulus(5'd31, 1'b0, 1'b1, 4, "s4_hold");
      applyStimulus(5'd31, 1'b0, 1'b0, 5, "s4_fall");
      checkVal("s4_fall5", 32'(Presencia), 1);
      applyStimulus(5'd31, 1'b0, 1'b0, 1, "s4_fall6");
      checkVal("s4_fall6", 32'(Presencia), 0);

      applyStimulus(5'd31, 1'b1, 1'b0, 4, "s5_pre");
      checkVal("s5_pre_motor", 32'(Motor), 0);
      Reset = 1'b0;
      applyStimulus(5'd31, 1'b1, 1'b0, 2, "s5_rst");
      checkVal("s5_rst_motor", 32'(Motor), 0);
      Reset = 1'b1;
      applyStimulus(5'd31, 1'b1, 1'b0, 5, "s5_post");
      checkVal("s5_edge5", 32'(Motor), 0);
      applyStimulus(5'd31, 1'b1, 1'b0, 1, "s5_post6");
      checkVal("s5_edge6", 32'(Motor), 1);
`endif

      rT = 5'd0;
      rM = 1'b0;
      rP = 1'b0;
      for (int seg = 0; seg < 150; seg++) begin
         if ($urandom_range(0, 3) == 0) rT = 5'($urandom);
         if ($urandom_range(0, 1) == 0) rM = ~rM;
         if ($urandom_range(0, 1) == 0) rP = ~rP;
         rLen = $urandom_range(1, 12);
         if (seg == 75) begin
            Reset = 1'b0;
            applyStimulus(rT, rM, rP, 3, "rand_rst");
            Reset = 1'b1;
         end
         applyStimulus(rT, rM, rP, rLen, "rand");
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
